windowed_register_file: RTL and testbench

//  Parametrised SPARC V8 windowed integer register file: globals plus NWINDOWS overlapping windows.

---
 rtl/windowed_register_file.sv | 119 +++++++++++
 tb/tb_windowed_register_file.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/windowed_register_file.sv
// SPARC V8 windowed integer register file: 8 globals plus NWINDOWS overlapping 16-register windows,
// with CWP/WIM state and registered overflow/underflow traps. Define WINDOW_BYPASS_EN for write-to-read forwarding.
module windowed_register_file #(
    parameter int WIDTH    = 32,
    parameter int NWINDOWS = 8,
    parameter int CWP_W    = 5
) (
    input  logic                Clk,
    input  logic                Clr,
    input  logic [4:0]          in_PA,
    input  logic [4:0]          in_PB,
    input  logic [4:0]          in_PC,
    input  logic                wr_en,
    input  logic [WIDTH-1:0]    wr_data,
    output logic [WIDTH-1:0]    out_PA,
    output logic [WIDTH-1:0]    out_PB,
    input  logic                save,
    input  logic                restore,
    input  logic                cwp_load,
    input  logic [CWP_W-1:0]    cwp_in,
    input  logic                wim_load,
    input  logic [NWINDOWS-1:0] wim_in,
    output logic [CWP_W-1:0]    cwp,
    output logic [NWINDOWS-1:0] wim,
    output logic                trap_ovf,
    output logic                trap_unf
);

    localparam int NPHYS = 8 + 16 * NWINDOWS;
    localparam int PW    = $clog2(NPHYS);

    logic [WIDTH-1:0]    regs_q [NPHYS];
    logic [CWP_W-1:0]    cwp_q, cwp_d;
    logic [NWINDOWS-1:0] wim_q, wim_d;
    logic                trap_ovf_q, trap_ovf_d;
    logic                trap_unf_q, trap_unf_d;

    // Ins of window w are the outs of window w+1, so they live at the next window's base.
    function automatic logic [PW-1:0] phys_idx(input logic [4:0] r, input logic [CWP_W-1:0] w);
        logic [CWP_W-1:0] wn;
        wn = (w == CWP_W'(NWINDOWS - 1)) ? '0 : w + 1'b1;
        if (r < 5'd8)
            phys_idx = PW'(r);
        else if (r < 5'd24)
            phys_idx = PW'(8) + PW'(16) * PW'(w) + PW'(r - 5'd8);
        else
            phys_idx = PW'(8) + PW'(16) * PW'(wn) + PW'(r - 5'd24);
    endfunction

    logic [PW-1:0] pa_idx, pb_idx, pc_idx;
    assign pa_idx = phys_idx(in_PA, cwp_q);
    assign pb_idx = phys_idx(in_PB, cwp_q);
    assign pc_idx = phys_idx(in_PC, cwp_q);

    always_comb begin
        out_PA = (in_PA == 5'd0) ? '0 : regs_q[pa_idx];
        out_PB = (in_PB == 5'd0) ? '0 : regs_q[pb_idx];
`ifdef WINDOW_BYPASS_EN
        if (wr_en && in_PC != 5'd0 && pa_idx == pc_idx) out_PA = wr_data;
        if (wr_en && in_PC != 5'd0 && pb_idx == pc_idx) out_PB = wr_data;
`endif
    end

    // Write address uses the pre-edge CWP even when a window move happens on the same edge.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            for (int i = 0; i < NPHYS; i++) regs_q[i] <= '0;
        end else if (wr_en && in_PC != 5'd0) begin
            regs_q[pc_idx] <= wr_data;
        end
    end

    logic [CWP_W-1:0] cwp_dec, cwp_inc;
    logic             dec_blocked, inc_blocked, cwp_in_ok;

    assign cwp_dec     = (cwp_q == '0) ? CWP_W'(NWINDOWS - 1) : cwp_q - 1'b1;
    assign cwp_inc     = (cwp_q == CWP_W'(NWINDOWS - 1)) ? '0 : cwp_q + 1'b1;
    assign dec_blocked = |(wim_q & (NWINDOWS'(1) << cwp_dec));
    assign inc_blocked = |(wim_q & (NWINDOWS'(1) << cwp_inc));
    assign cwp_in_ok   = {1'b0, cwp_in} < (CWP_W + 1)'(NWINDOWS);

    always_comb begin
        cwp_d      = cwp_q;
        trap_ovf_d = 1'b0;
        trap_unf_d = 1'b0;
        wim_d      = wim_load ? wim_in : wim_q;
        if (cwp_load) begin
            if (cwp_in_ok) cwp_d = cwp_in;
        end else if (save && restore) begin
            cwp_d = cwp_q;
        end else if (save) begin
            if (dec_blocked) trap_ovf_d = 1'b1;
            else             cwp_d      = cwp_dec;
        end else if (restore) begin
            if (inc_blocked) trap_unf_d = 1'b1;
            else             cwp_d      = cwp_inc;
        end
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            cwp_q      <= '0;
            wim_q      <= '0;
            trap_ovf_q <= 1'b0;
            trap_unf_q <= 1'b0;
        end else begin
            cwp_q      <= cwp_d;
            wim_q      <= wim_d;
            trap_ovf_q <= trap_ovf_d;
            trap_unf_q <= trap_unf_d;
        end
    end

    assign cwp      = cwp_q;
    assign wim      = wim_q;
    assign trap_ovf = trap_ovf_q;
    assign trap_unf = trap_unf_q;

endmodule

// File: tb/tb_windowed_register_file.sv
// Bench for windowed_register_file: an 8-window/32-bit and a 4-window/16-bit instance share one stimulus stream
// and are checked every cycle against an array-based window model, plus directed literal checks.
module tb_windowed_register_file;

  logic        Clk = 1'b0;
  logic        Clr = 1'b1;
  logic [4:0]  pa, pb, pc;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        save, restore, cwp_load, wim_load;
  logic [4:0]  cwp_in;
  logic [7:0]  wim_in;

  logic [31:0] a8, b8;
  logic [4:0]  cwp8;
  logic [7:0]  wim8;
  logic        ovf8, unf8;
  logic [15:0] a4, b4;
  logic [4:0]  cwp4;
  logic [3:0]  wim4;
  logic        ovf4, unf4;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  always #5 Clk = ~Clk;

  windowed_register_file #(.WIDTH(32), .NWINDOWS(8), .CWP_W(5)) dut8 (
    .Clk(Clk), .Clr(Clr), .in_PA(pa), .in_PB(pb), .in_PC(pc), .wr_en(wr_en),
    .wr_data(wr_data), .out_PA(a8), .out_PB(b8), .save(save), .restore(restore),
    .cwp_load(cwp_load), .cwp_in(cwp_in), .wim_load(wim_load), .wim_in(wim_in),
    .cwp(cwp8), .wim(wim8), .trap_ovf(ovf8), .trap_unf(unf8)
  );

  windowed_register_file #(.WIDTH(16), .NWINDOWS(4), .CWP_W(5)) dut4 (
    .Clk(Clk), .Clr(Clr), .in_PA(pa), .in_PB(pb), .in_PC(pc), .wr_en(wr_en),
    .wr_data(wr_data[15:0]), .out_PA(a4), .out_PB(b4), .save(save), .restore(restore),
    .cwp_load(cwp_load), .cwp_in(cwp_in), .wim_load(wim_load), .wim_in(wim_in[3:0]),
    .cwp(cwp4), .wim(wim4), .trap_ovf(ovf4), .trap_unf(unf4)
  );

  // Reference model: index 0 is the 8-window instance, index 1 the 4-window one.
  logic [31:0] m_reg [2][520];
  int          m_cwp [2];
  logic [31:0] m_wim [2];
  logic        m_ovf [2];
  logic        m_unf [2];

  function automatic int nw_of(int k);
    return (k == 0) ? 8 : 4;
  endfunction

  function automatic logic [31:0] dmask(int k);
    return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  function automatic int phys(int k, int r, int w);
    if (r < 8)  return r;
    if (r < 24) return 8 + 16 * w + (r - 8);
    return 8 + 16 * ((w + 1) % nw_of(k)) + (r - 24);
  endfunction

  function automatic logic [31:0] exp_rd(int k, int r);
    int a;
    a = phys(k, r, m_cwp[k]);
    if (r == 0) return 32'd0;
`ifdef WINDOW_BYPASS_EN
    if (wr_en && pc != 5'd0 && phys(k, int'(pc), m_cwp[k]) == a) return wr_data & dmask(k);
`endif
    return m_reg[k][a];
  endfunction

  task automatic m_clear();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 520; i++) m_reg[k][i] = 32'd0;
      m_cwp[k] = 0;
      m_wim[k] = 32'd0;
      m_ovf[k] = 1'b0;
      m_unf[k] = 1'b0;
    end
  endtask

  task automatic m_step();
    for (int k = 0; k < 2; k++) begin
      int nw;
      int nxt;
      logic [31:0] wnew;
      nw = nw_of(k);
      if (wr_en && pc != 5'd0) m_reg[k][phys(k, int'(pc), m_cwp[k])] = wr_data & dmask(k);
      wnew = wim_load ? ({24'd0, wim_in} & ((32'd1 << nw) - 32'd1)) : m_wim[k];
      m_ovf[k] = 1'b0;
      m_unf[k] = 1'b0;
      if (cwp_load) begin
        if (int'(cwp_in) < nw) m_cwp[k] = int'(cwp_in);
      end else if (save && restore) begin
        m_cwp[k] = m_cwp[k];
      end else if (save) begin
        nxt = (m_cwp[k] + nw - 1) % nw;
        if (m_wim[k][nxt]) m_ovf[k] = 1'b1;
        else m_cwp[k] = nxt;
      end else if (restore) begin
        nxt = (m_cwp[k] + 1) % nw;
        if (m_wim[k][nxt]) m_unf[k] = 1'b1;
        else m_cwp[k] = nxt;
      end
      m_wim[k] = wnew;
    end
  endtask

  always @(posedge Clk or negedge Clr) begin
    if (!Clr) m_clear();
    else m_step();
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", nm, $time, got, exp);
    end
  endtask

  task automatic cmp(input int k, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                     input logic [31:0] w, input logic o, input logic u);
    chk($sformatf("dut%0d out_PA r%0d", k, pa), a, exp_rd(k, int'(pa)));
    chk($sformatf("dut%0d out_PB r%0d", k, pb), b, exp_rd(k, int'(pb)));
    chk($sformatf("dut%0d cwp", k), c, 32'(m_cwp[k]));
    chk($sformatf("dut%0d wim", k), w, m_wim[k]);
    chk($sformatf("dut%0d trap_ovf", k), {31'd0, o}, {31'd0, m_ovf[k]});
    chk($sformatf("dut%0d trap_unf", k), {31'd0, u}, {31'd0, m_unf[k]});
  endtask

  always @(negedge Clk) begin
    if (chk_on) begin
      cmp(0, a8, b8, {27'd0, cwp8}, {24'd0, wim8}, ovf8, unf8);
      cmp(1, {16'd0, a4}, {16'd0, b4}, {27'd0, cwp4}, {28'd0, wim4}, ovf4, unf4);
    end
  end

  task automatic idle();
    pa = 5'd0; pb = 5'd0; pc = 5'd0; wr_en = 1'b0; wr_data = 32'd0;
    save = 1'b0; restore = 1'b0; cwp_load = 1'b0; cwp_in = 5'd0;
    wim_load = 1'b0; wim_in = 8'd0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  initial begin
    int r;
    idle();
    #1 Clr = 1'b0;
    chk_on = 1'b1;
    #2;
    chk("reset cwp", {27'd0, cwp8}, 32'd0);
    chk("reset wim", {24'd0, wim8}, 32'd0);
    chk("reset traps", {30'd0, ovf8, unf8}, 32'd0);
    @(negedge Clk);
    #2 Clr = 1'b1;

    // Write r1, then attempt a write to r0.
    pc = 5'd1; wr_en = 1'b1; wr_data = 32'hA5A5_A5A5;
    tick();
    pc = 5'd0; wr_data = 32'hFFFF_FFFF; pa = 5'd1; pb = 5'd0;
    #1;
    chk("t1 r1", a8, 32'hA5A5_A5A5);
    chk("t1 r1 narrow", {16'd0, a4}, 32'h0000_A5A5);
    chk("t1 r0", b8, 32'd0);
    chk("t1 cwp", {27'd0, cwp8}, 32'd0);
    tick();
    idle();
    #1 chk("t1 r0 after write", b8, 32'd0);

    // Out written in window 0 becomes an in of the window entered by save.
    pc = 5'd8; wr_en = 1'b1; wr_data = 32'h11;
    tick();
    idle(); save = 1'b1;
    tick();
    idle(); pa = 5'd24; pb = 5'd8;
    #1;
    chk("t2 cwp", {27'd0, cwp8}, 32'd7);
    chk("t2 cwp narrow", {27'd0, cwp4}, 32'd3);
    chk("t2 r24", a8, 32'h11);
    chk("t2 r24 narrow", {16'd0, a4}, 32'h11);
    chk("t2 r8", b8, 32'd0);

    // Restore into an invalid window traps; save into a valid one does not.
    idle(); cwp_load = 1'b1; cwp_in = 5'd0; wim_load = 1'b1; wim_in = 8'h02;
    tick();
    idle(); restore = 1'b1;
    tick();
    idle();
    #1;
    chk("t3 unf pulse", {31'd0, unf8}, 32'd1);
    chk("t3 cwp held", {27'd0, cwp8}, 32'd0);
    chk("t3 wim", {24'd0, wim8}, 32'h02);
    tick();
    #1 chk("t3 unf cleared", {31'd0, unf8}, 32'd0);
    save = 1'b1;
    tick();
    idle();
    #1;
    chk("t3 save cwp", {27'd0, cwp8}, 32'd7);
    chk("t3 no ovf", {31'd0, ovf8}, 32'd0);

    // Conflicting window requests.
    save = 1'b1; restore = 1'b1;
    tick();
    idle();
    #1;
    chk("t4 both cwp", {27'd0, cwp8}, 32'd7);
    chk("t4 both traps", {30'd0, ovf8, unf8}, 32'd0);
    cwp_load = 1'b1; cwp_in = 5'd9; save = 1'b1;
    tick();
    idle();
    #1;
    chk("t4 bad load cwp", {27'd0, cwp8}, 32'd7);
    chk("t4 bad load cwp narrow", {27'd0, cwp4}, 32'd3);
    chk("t4 bad load ovf", {31'd0, ovf8}, 32'd0);

    // Same-cycle write and read of a global.
    pc = 5'd5; wr_en = 1'b1; wr_data = 32'h77; pa = 5'd5;
    #1;
`ifdef WINDOW_BYPASS_EN
    chk("t5 same-cycle r5", a8, 32'h77);
`else
    chk("t5 same-cycle r5", a8, 32'd0);
`endif
    tick();
    idle(); pa = 5'd5;
    #1 chk("t5 next-cycle r5", a8, 32'h77);

    // Async reset while an overflow pulse is being driven.
    idle(); wim_load = 1'b1; wim_in = 8'h44;
    tick();
    idle(); save = 1'b1;
    tick();
    idle();
    #1;
    chk("t6 ovf pending", {31'd0, ovf8}, 32'd1);
    chk("t6 ovf pending narrow", {31'd0, ovf4}, 32'd1);
    Clr = 1'b0;
    #1;
    chk("t6 cwp cleared", {27'd0, cwp8}, 32'd0);
    chk("t6 ovf cleared", {31'd0, ovf8}, 32'd0);
    chk("t6 wim cleared", {24'd0, wim8}, 32'd0);
    chk("t6 cwp cleared narrow", {27'd0, cwp4}, 32'd0);
    chk("t6 ovf cleared narrow", {31'd0, ovf4}, 32'd0);
    @(negedge Clk);
    #2 Clr = 1'b1;
    pa = 5'd5; save = 1'b1;
    tick();
    idle(); pa = 5'd5;
    #1;
    chk("t6 post-reset save", {27'd0, cwp8}, 32'd7);
    chk("t6 post-reset save narrow", {27'd0, cwp4}, 32'd3);
    chk("t6 post-reset r5", a8, 32'd0);

    // Randomized traffic, with one asynchronous reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      pa = 5'($urandom_range(0, 31));
      pb = 5'($urandom_range(0, 31));
      pc = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 4) == 0) pa = pc;
      if ($urandom_range(0, 6) == 0) pb = pc;
      wr_en = 1'($urandom_range(0, 1));
      wr_data = $urandom;
      r = int'($urandom_range(0, 99));
      save = (r < 30) || (r >= 55 && r < 60);
      restore = (r >= 30 && r < 60);
      cwp_load = (r >= 60 && r < 64);
      cwp_in = 5'($urandom_range(0, 11));
      wim_load = ($urandom_range(0, 15) == 0);
      wim_in = 8'($urandom & $urandom);
      tick();
      if (c == 1500) begin
        #1 Clr = 1'b0;
        @(negedge Clk);
        #2 Clr = 1'b1;
      end
    end

    idle();
    tick();
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
